// File: rtl/recirc_pkg.sv
// Shared state type, statistics width and sizing helper for the recirculation router.
package recirc_pkg;

    typedef enum logic {
        RECIRC  = 1'b0,
        FORWARD = 1'b1
    } state_t;

    localparam int STAT_W = 16;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/recirc_router_param_if.sv
// Lane bus between the lane source, the recirculation router and the demux stage.
interface recirc_router_param_if #(
    parameter int CH = 4,
    parameter int W  = 8
);
    logic [CH*W-1:0]                  data_in;
    logic [CH-1:0]                    valid_in;
    logic                             idle_in;
    logic [CH*W-1:0]                  data_rc;
    logic [CH-1:0]                    valid_rc;
    logic [CH*W-1:0]                  data_out;
    logic [CH-1:0]                    valid_out;
    logic                             fwd_mode;
    logic                             timeout_err;
    logic [CH*recirc_pkg::STAT_W-1:0] stat_cnt;

    modport master (
        output data_in, valid_in, idle_in,
        input  data_rc, valid_rc, data_out, valid_out, fwd_mode, timeout_err, stat_cnt
    );

    modport slave (
        input  data_in, valid_in, idle_in,
        output data_rc, valid_rc, data_out, valid_out, fwd_mode, timeout_err, stat_cnt
    );
endinterface

// File: rtl/recirc_lane.sv
// One lane: registers the incoming word together with its route, then steers it to
// either the recirculation or the forward output; invalid words read as zero.
module recirc_lane #(
    parameter int W = 8
) (
    input  logic         clk_f,
    input  logic         reset,
    input  logic [W-1:0] word,
    input  logic         valid,
    input  logic         route_fwd,
    output logic [W-1:0] data_rc,
    output logic         valid_rc,
    output logic [W-1:0] data_out,
    output logic         valid_out
);
    logic [W-1:0] word_q;
    logic         valid_q;
    logic         fwd_q;

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            fwd_q   <= 1'b0;
        end else begin
            word_q  <= valid ? word : '0;
            valid_q <= valid;
            fwd_q   <= route_fwd;
        end
    end

    assign data_rc   = fwd_q ? '0 : word_q;
    assign valid_rc  = valid_q & ~fwd_q;
    assign data_out  = fwd_q ? word_q : '0;
    assign valid_out = valid_q & fwd_q;

endmodule

// File: rtl/recirc_router_param.sv
// Recirculation front end: lane words loop back until downstream idle is debounced, then
// go forward. Optional per-lane forwarded-word counters are built when RECIRC_STATS_EN is defined.
module recirc_router_param
    import recirc_pkg::*;
#(
    parameter int CH        = 4,
    parameter int W         = 8,
    parameter int IDLE_SYNC = 2,
    parameter int TIMEOUT   = 255
) (
    input logic                  clk_f,
    input logic                  reset,
    recirc_router_param_if.slave bus
);
    localparam int                CNT_W     = clog2(TIMEOUT + 1);
    localparam int                IDLE_W    = clog2(IDLE_SYNC);
    localparam logic [CNT_W-1:0]  RC_MAX    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  RC_PRE    = CNT_W'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_SYNC - 1);

    state_t               state;
    state_t               next_state;
    logic [IDLE_W-1:0]    idle_cnt;
    logic [CNT_W-1:0]     rc_cnt;
    logic                 timeout_q;
    logic                 route_fwd;
    logic [CH*W-1:0]      rc_data;
    logic [CH*W-1:0]      fwd_data;
    logic [CH-1:0]        rc_valid;
    logic [CH-1:0]        fwd_valid;
    logic [CH*STAT_W-1:0] stat_data;

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            state <= RECIRC;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RECIRC:  if (bus.idle_in && idle_cnt == IDLE_LAST) next_state = FORWARD;
            FORWARD: if (!bus.idle_in) next_state = RECIRC;
            default: next_state = RECIRC;
        endcase
    end

    // Routing follows the state being entered, so the word on a transition edge already takes the new path.
    always_comb begin
        route_fwd       = (next_state == FORWARD);
        bus.fwd_mode    = (state == FORWARD);
        bus.timeout_err = timeout_q;
    end

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (!bus.idle_in) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_LAST) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Leaving RECIRC clears the count, but a count that already saturated still raises the flag.
    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            rc_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (next_state == FORWARD) begin
                rc_cnt <= '0;
            end else if (state == RECIRC && rc_cnt != RC_MAX) begin
                rc_cnt <= rc_cnt + 1'b1;
            end
            if (rc_cnt == RC_MAX ||
                (state == RECIRC && next_state == RECIRC && rc_cnt == RC_PRE)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_lane
        recirc_lane #(.W(W)) u_lane (
            .clk_f     (clk_f),
            .reset     (reset),
            .word      (bus.data_in[i*W +: W]),
            .valid     (bus.valid_in[i]),
            .route_fwd (route_fwd),
            .data_rc   (rc_data[i*W +: W]),
            .valid_rc  (rc_valid[i]),
            .data_out  (fwd_data[i*W +: W]),
            .valid_out (fwd_valid[i])
        );
    end

`ifdef RECIRC_STATS_EN
    for (genvar i = 0; i < CH; i++) begin : g_stat
        logic [STAT_W-1:0] stat_q;

        always_ff @(posedge clk_f or negedge reset) begin
            if (!reset) begin
                stat_q <= '0;
            end else if (route_fwd && bus.valid_in[i]) begin
                stat_q <= stat_q + 1'b1;
            end
        end

        assign stat_data[i*STAT_W +: STAT_W] = stat_q;
    end
`else
    assign stat_data = '0;
`endif

    assign bus.data_rc   = rc_data;
    assign bus.valid_rc  = rc_valid;
    assign bus.data_out  = fwd_data;
    assign bus.valid_out = fwd_valid;
    assign bus.stat_cnt  = stat_data;

endmodule

// File: tb/tb_recirc_router_param.sv
// Bench for recirc_router_param: directed and random lane traffic against a run-length
// based reference model of routing, idle debounce, watchdog and statistics.
module tb_recirc_router_param;
    localparam int CH        = 4;
    localparam int W         = 8;
    localparam int IDLE_SYNC = 2;
    localparam int TIMEOUT   = 255;
`ifdef RECIRC_STATS_EN
    localparam bit STATS_BUILT = 1'b1;
`else
    localparam bit STATS_BUILT = 1'b0;
`endif

    logic clk_f = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    int              idle_run;
    bit              fwd_m;
    int              rc_time;
    bit              err_m;
    int              stat_m [CH];
    logic [CH*W-1:0] exp_data_rc;
    logic [CH*W-1:0] exp_data_out;
    logic [CH-1:0]   exp_valid_rc;
    logic [CH-1:0]   exp_valid_out;

    recirc_router_param_if #(.CH(CH), .W(W)) bus ();

    recirc_router_param #(
        .CH        (CH),
        .W         (W),
        .IDLE_SYNC (IDLE_SYNC),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_f (clk_f),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_f = ~clk_f;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        idle_run      = 0;
        fwd_m         = 1'b0;
        rc_time       = 0;
        err_m         = 1'b0;
        exp_data_rc   = '0;
        exp_data_out  = '0;
        exp_valid_rc  = '0;
        exp_valid_out = '0;
        for (int i = 0; i < CH; i++) stat_m[i] = 0;
    endtask

    // Forward mode holds exactly while idle has been seen on IDLE_SYNC or more consecutive edges.
    task automatic model_edge(input logic [CH*W-1:0] d, input logic [CH-1:0] v, input logic idle);
        bit was_fwd;
        was_fwd  = fwd_m;
        idle_run = idle ? ((idle_run < 1000) ? idle_run + 1 : idle_run) : 0;
        fwd_m    = (idle_run >= IDLE_SYNC);
        if (fwd_m) rc_time = 0;
        else if (!was_fwd && rc_time < TIMEOUT) rc_time = rc_time + 1;
        if (rc_time == TIMEOUT) err_m = 1'b1;
        exp_data_rc   = '0;
        exp_data_out  = '0;
        exp_valid_rc  = '0;
        exp_valid_out = '0;
        for (int i = 0; i < CH; i++) begin
            if (v[i]) begin
                if (fwd_m) begin
                    exp_data_out[i*W +: W] = d[i*W +: W];
                    exp_valid_out[i]       = 1'b1;
                    stat_m[i]              = (stat_m[i] + 1) % 65536;
                end else begin
                    exp_data_rc[i*W +: W] = d[i*W +: W];
                    exp_valid_rc[i]       = 1'b1;
                end
            end
        end
    endtask

    task automatic check_output();
        logic [63:0] stat_pack;
        logic [63:0] stat_exp;
        stat_pack = '0;
        for (int i = 0; i < CH; i++) stat_pack[i*16 +: 16] = 16'(stat_m[i]);
        stat_exp = STATS_BUILT ? stat_pack : 64'h0;
        check("data_rc",     64'(bus.data_rc),     64'(exp_data_rc));
        check("valid_rc",    64'(bus.valid_rc),    64'(exp_valid_rc));
        check("data_out",    64'(bus.data_out),    64'(exp_data_out));
        check("valid_out",   64'(bus.valid_out),   64'(exp_valid_out));
        check("fwd_mode",    64'(bus.fwd_mode),    64'(fwd_m));
        check("timeout_err", 64'(bus.timeout_err), 64'(err_m));
        check("stat_cnt",    64'(bus.stat_cnt),    stat_exp);
    endtask

    task automatic apply_stimulus(input logic [CH*W-1:0] d, input logic [CH-1:0] v, input logic idle);
        @(negedge clk_f);
        bus.data_in  = d;
        bus.valid_in = v;
        bus.idle_in  = idle;
        @(posedge clk_f);
        model_edge(d, v, idle);
        #1;
        check_output();
    endtask

    function automatic logic [CH*W-1:0] rand_word();
        return (CH*W)'($urandom);
    endfunction

    initial begin
        bus.data_in  = '0;
        bus.valid_in = '0;
        bus.idle_in  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_f);
        #1;
        check_output();
        @(posedge clk_f);
        #2;
        reset = 1'b1;

        apply_stimulus(32'hccddeeff, 4'hf, 1'b0);
        check("first_rc_word", 64'(bus.data_rc), 64'h0000_0000_ccdd_eeff);
        check("first_no_fwd",  64'(bus.valid_out), 64'h0);

        apply_stimulus(rand_word(), 4'h0, 1'b1);
        check("debounce_first_edge", 64'(bus.fwd_mode), 64'h0);
        apply_stimulus(32'h8899aabb, 4'hf, 1'b1);
        check("fwd_on_second_edge", 64'(bus.fwd_mode), 64'h1);
        check("transition_word_fwd", 64'(bus.data_out), 64'h0000_0000_8899_aabb);

        apply_stimulus(32'h12347756, 4'h2, 1'b1);
        check("single_lane_data",  64'(bus.data_out),  64'h0000_0000_0000_7700);
        check("single_lane_valid", 64'(bus.valid_out), 64'h2);

        for (int k = 0; k < 40; k++)
            apply_stimulus(rand_word(), 4'($urandom), ($urandom_range(0, 9) < 7));

        for (int k = 0; k < 22; k++)
            apply_stimulus(rand_word(), 4'($urandom), 1'b1);

        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_output();
        check("async_reset_mode", 64'(bus.fwd_mode), 64'h0);
        @(posedge clk_f);
        #2;
        reset = 1'b1;

        for (int k = 1; k <= TIMEOUT; k++) begin
            apply_stimulus(rand_word(), 4'($urandom), 1'b0);
            if (k == 1)           check("recirc_after_reset", 64'(bus.fwd_mode), 64'h0);
            if (k == TIMEOUT - 1) check("watchdog_not_yet", 64'(bus.timeout_err), 64'h0);
            if (k == TIMEOUT)     check("watchdog_fires", 64'(bus.timeout_err), 64'h1);
        end

        apply_stimulus(rand_word(), 4'hf, 1'b1);
        apply_stimulus(rand_word(), 4'hf, 1'b1);
        check("watchdog_sticky", 64'(bus.timeout_err), 64'h1);
        check("fwd_despite_err", 64'(bus.fwd_mode), 64'h1);

        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_output();
        check("watchdog_cleared", 64'(bus.timeout_err), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
